b2s_tx_scheduler: RTL and testbench
===================================

Name: b2s_tx_scheduler

Overview:
Shares one b2s serial transmitter core among N_REQ requesters. Round-robin arbitration selects one pending requester and latches its word. The block then issues a one-cycle start pulse to the core, supervises the frame with a timeout watchdog, and enforces an idle gap on the line between frames. It sits between the command sources (e.g. reset/presence and data sequencers) and the b2s transmitter core.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 32, data word width sent per frame
GAP_CYC, 1000, minimum clk cycles between tx_done/abort and the next tx_start
TIMEOUT_CYC, 65535, clk cycles allowed from tx_start to tx_done before abort
CNT_W, 16, width of the gap and timeout counters; must hold max(GAP_CYC, TIMEOUT_CYC)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req  in  N_REQ  per-requester request level; held high until gnt
req_data  in  N_REQ*WIDTH  packed words; requester i uses bits [i*WIDTH +: WIDTH]
gnt  out  N_REQ  one-hot, one-cycle pulse; word latched
frm_done  out  N_REQ  one-hot, one-cycle pulse; frame completed normally
frm_err  out  N_REQ  one-hot, one-cycle pulse; frame aborted on timeout
tx_start  out  1  one-cycle start pulse to the core
tx_din  out  WIDTH  word to the core, stable from tx_start until tx_done or abort
tx_abort  out  1  one-cycle pulse forcing the core back to its init state
tx_done  in  1  one-cycle pulse from the core at end of frame
cur_id  out  $clog2(N_REQ)  index of the current or last owner
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - gnt, frm_done, frm_err, tx_start, tx_abort, busy = 0
  - tx_din = 0, cur_id = 0, state = IDLE
  - rr pointer = N_REQ-1, so req[0] has top priority first
  - counters = 0
- Reset mid-frame: all of the above apply immediately. No frm_done or frm_err is reported for the interrupted frame. The core is reset by the same rst.
- States: IDLE, RUN, GAP.
- IDLE, req != 0 sampled at edge k:
  - Winner w = first set bit searching from ptr+1 upward, mod N_REQ.
  - At edge k the block registers: gnt[w]=1, tx_start=1, tx_din=req_data[w], cur_id=w, ptr=w, state=RUN, timeout counter=0.
  - Latency is 1 cycle from req visible to gnt/tx_start.
- gnt and tx_start are asserted together for exactly 1 cycle. The requester drops req or presents a new word after gnt.
- A requester that drops req before gnt is not granted. No state is kept for it.
- RUN: timeout counter increments every cycle.
  - tx_done=1: next cycle frm_done[cur_id]=1, state=GAP, gap counter=0.
  - Else counter == TIMEOUT_CYC-1: next cycle frm_err[cur_id]=1, tx_abort=1, state=GAP.
  - tx_done in the same cycle as timeout expiry: done wins; no error and no abort.
- tx_done outside RUN is ignored. A bench assertion flags it.
- GAP: gap counter increments each cycle. At GAP_CYC-1 the state returns to IDLE.
  - Requests are not evaluated in GAP.
  - The earliest next tx_start is GAP_CYC+1 cycles after the frm_done pulse.
- GAP_CYC=0 behaves as 1 (one GAP cycle minimum).
- Fairness: with all requests held, grants rotate 0,1,2,...,N_REQ-1,0. No requester waits more than N_REQ-1 frames.
- ptr updates only on grant, never on abort.
- tx_din keeps its value after a frame completes, until the next grant.
- Counters saturate and never wrap. A timeout counter stuck at TIMEOUT_CYC-1 is unreachable by construction.

Decomposition:
- Package b2s_pkg holds:
  - state enum {IDLE, RUN, GAP}
  - default WIDTH (32) and N_REQ (4)
  - localparam ID_W = $clog2(N_REQ)
- Sub-module b2s_rr_arb: combinational round-robin picker.
  - Inputs: req, ptr.
  - Outputs: any, one-hot win, win_id.
- The FSM, counters and output registers stay in b2s_tx_scheduler.

Test Plan:
- Single frame: req[2]=1 with data 0xA5A5_0001; core done after 500 cycles.
  - gnt[2] and tx_start high 1 cycle later; tx_din=0xA5A5_0001.
  - frm_done[2] one cycle after tx_done; next start no earlier than GAP_CYC+1 cycles later.
- Round-robin: req=4'b1111 held, each word re-presented after its gnt.
  - Grant order 0,1,2,3,0.
  - Then with req=4'b1010 after granting 1: next grant 3, then 1.
- Timeout: TIMEOUT_CYC=100, core never sends tx_done.
  - frm_err[cur_id] and tx_abort pulse 101 cycles after tx_start; no frm_done; ptr advanced past that requester.
- Done/timeout collision: tx_done asserted exactly at counter == TIMEOUT_CYC-1.
  - frm_done pulse; no frm_err; no tx_abort.
- Reset mid-RUN: rst asserted 50 cycles after tx_start.
  - All outputs 0 asynchronously; after release the next grant goes to req[0] if pending.
- Request withdrawn during GAP: req[1] pulsed for 10 cycles inside GAP only.
  - No gnt[1]; block returns to IDLE with busy=0.

Source files
------------

// File: rtl/b2s_tx_scheduler_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | b2s_pkg : shared types and constants for the b2s transmit scheduler |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package b2s_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 32;
  localparam int ID_W      = $clog2(N_REQ_DEF);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/b2s_tx_scheduler_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | b2s_tx_scheduler_if : requester and transmitter-core signal bundle   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface b2s_tx_scheduler_if
  import b2s_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
);
  localparam int IDW = id_width(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       frm_done;
  logic [N_REQ-1:0]       frm_err;
  logic                   tx_start;
  logic [WIDTH-1:0]       tx_din;
  logic                   tx_abort;
  logic                   tx_done;
  logic [IDW-1:0]         cur_id;
  logic                   busy;

  modport master (
    input  req, req_data, tx_done,
    output gnt, frm_done, frm_err, tx_start, tx_din, tx_abort, cur_id, busy
  );

  modport slave (
    output req, req_data, tx_done,
    input  gnt, frm_done, frm_err, tx_start, tx_din, tx_abort, cur_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/b2s_tx_scheduler_rr_arb.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | b2s_rr_arb : combinational round-robin picker, search from ptr+1     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module b2s_rr_arb
  import b2s_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDW   = id_width(N_REQ)
) (
  input  wire logic [N_REQ-1:0] i_req,
  input  wire logic [IDW-1:0]   i_ptr,
  output logic                  o_any,
  output logic [N_REQ-1:0]      o_win,
  output logic [IDW-1:0]        o_win_id
);

  always_comb begin
    int  idx;
    logic found;
    o_any    = |i_req;
    o_win    = '0;
    o_win_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(i_ptr) + k) % N_REQ;
      if (!found && i_req[idx]) begin
        found         = 1'b1;
        o_win[idx]    = 1'b1;
        o_win_id      = IDW'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/b2s_tx_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | b2s_tx_scheduler : shares one b2s transmitter among N_REQ requesters |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module b2s_tx_scheduler
  import b2s_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int GAP_CYC     = 1000,
  parameter int TIMEOUT_CYC = 65535,
  parameter int CNT_W       = 16
) (
  input  wire logic           clk,
  input  wire logic           rst,
  b2s_tx_scheduler_if.master  bus
);

  localparam int               IDW      = id_width(N_REQ);
  localparam int               GAP_EFF  = (GAP_CYC < 1) ? 1 : GAP_CYC;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_EFF - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_tcnt;
  logic [CNT_W-1:0]   r_gcnt;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_cur_id;
  logic [WIDTH-1:0]   r_tx_din;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_frm_done;
  logic [N_REQ-1:0]   r_frm_err;
  logic               r_tx_start;
  logic               r_tx_abort;

  logic               w_any;
  logic [N_REQ-1:0]   w_win;
  logic [IDW-1:0]     w_win_id;
  logic [N_REQ-1:0]   w_cur_oh;

  b2s_rr_arb #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_any    (w_any),
    .o_win    (w_win),
    .o_win_id (w_win_id)
  );

  assign w_cur_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_cur_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tcnt     <= '0;
      r_gcnt     <= '0;
      r_ptr      <= IDW'(N_REQ - 1);
      r_cur_id   <= '0;
      r_tx_din   <= '0;
      r_gnt      <= '0;
      r_frm_done <= '0;
      r_frm_err  <= '0;
      r_tx_start <= 1'b0;
      r_tx_abort <= 1'b0;
    end else begin
      r_gnt      <= '0;
      r_frm_done <= '0;
      r_frm_err  <= '0;
      r_tx_start <= 1'b0;
      r_tx_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt      <= w_win;
            r_tx_start <= 1'b1;
            r_tx_din   <= bus.req_data[w_win_id*WIDTH +: WIDTH];
            r_cur_id   <= w_win_id;
            r_ptr      <= w_win_id;
            r_tcnt     <= '0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // The start-pulse cycle is not counted, so expiry lands TIMEOUT_CYC+1 cycles after tx_start.
          if (bus.tx_done) begin
            r_frm_done <= w_cur_oh;
            r_gcnt     <= '0;
            r_state    <= ST_GAP;
          end else if (!r_tx_start && r_tcnt == TO_LAST) begin
            r_frm_err  <= w_cur_oh;
            r_tx_abort <= 1'b1;
            r_gcnt     <= '0;
            r_state    <= ST_GAP;
          end else if (!r_tx_start && r_tcnt != CNT_MAX) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gcnt == GAP_LAST) begin
            r_state <= ST_IDLE;
          end else if (r_gcnt != CNT_MAX) begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.frm_done = r_frm_done;
  assign bus.frm_err  = r_frm_err;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_din   = r_tx_din;
  assign bus.tx_abort = r_tx_abort;
  assign bus.cur_id   = r_cur_id;
  assign bus.busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_b2s_tx_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_b2s_tx_scheduler : directed self-checking bench for the scheduler |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_b2s_tx_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  b2s_tx_scheduler_if #(.N_REQ(4), .WIDTH(32)) ifa ();
  b2s_tx_scheduler_if #(.N_REQ(4), .WIDTH(32)) ift ();

  b2s_tx_scheduler #(.N_REQ(4), .WIDTH(32), .GAP_CYC(10), .TIMEOUT_CYC(1000), .CNT_W(16)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  b2s_tx_scheduler #(.N_REQ(4), .WIDTH(32), .GAP_CYC(10), .TIMEOUT_CYC(100), .CNT_W(16)) dut_t (
    .clk (clk), .rst (rst), .bus (ift)
  );

  // tx_done while the scheduler is idle must never be produced by this bench
  always @(posedge clk) begin
    if (!rst && ((ifa.tx_done && !ifa.busy) || (ift.tx_done && !ift.busy))) begin
      errors++;
      $display("FAIL tx_done_outside_run: tx_done seen while busy=0");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.req = '0; ifa.req_data = '0; ifa.tx_done = 1'b0;
    ift.req = '0; ift.req_data = '0; ift.tx_done = 1'b0;
    repeat (3) step();
    checks++; if (ifa.gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", ifa.gnt); end
    checks++; if (ifa.frm_done !== 4'b0 || ifa.frm_err !== 4'b0) begin errors++; $display("FAIL reset_frm: done %b err %b want 0", ifa.frm_done, ifa.frm_err); end
    checks++; if (ifa.tx_start !== 1'b0 || ifa.tx_abort !== 1'b0) begin errors++; $display("FAIL reset_pulses: start %b abort %b want 0", ifa.tx_start, ifa.tx_abort); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ifa.busy); end
    checks++; if (ifa.tx_din !== 32'h0 || ifa.cur_id !== 2'd0) begin errors++; $display("FAIL reset_din_id: din %h id %0d want 0", ifa.tx_din, ifa.cur_id); end
    checks++; if (ift.busy !== 1'b0 || ift.tx_din !== 32'h0) begin errors++; $display("FAIL reset_t: busy %b din %h want 0", ift.busy, ift.tx_din); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    int n;
    ifa.req_data[2*32 +: 32] = 32'hA5A5_0001;
    ifa.req = 4'b0100;
    step();
    checks++; if (ifa.gnt !== 4'b0100 || ifa.tx_start !== 1'b1) begin errors++; $display("FAIL single_grant: gnt %b start %b want 0100 1", ifa.gnt, ifa.tx_start); end
    checks++; if (ifa.tx_din !== 32'hA5A5_0001 || ifa.cur_id !== 2'd2) begin errors++; $display("FAIL single_din: din %h id %0d want a5a50001 2", ifa.tx_din, ifa.cur_id); end
    ifa.req = '0;
    ifa.req_data[2*32 +: 32] = 32'h0;
    step();
    checks++; if (ifa.gnt !== 4'b0 || ifa.tx_start !== 1'b0 || ifa.busy !== 1'b1) begin errors++; $display("FAIL single_pulse_len: gnt %b start %b busy %b want 0000 0 1", ifa.gnt, ifa.tx_start, ifa.busy); end
    repeat (498) step();
    ifa.tx_done = 1'b1;
    step();
    ifa.tx_done = 1'b0;
    checks++; if (ifa.frm_done !== 4'b0100 || ifa.frm_err !== 4'b0 || ifa.tx_abort !== 1'b0) begin errors++; $display("FAIL single_done: done %b err %b abort %b want 0100 0000 0", ifa.frm_done, ifa.frm_err, ifa.tx_abort); end
    checks++; if (ifa.tx_din !== 32'hA5A5_0001) begin errors++; $display("FAIL single_din_hold: got %h want a5a50001", ifa.tx_din); end
    ifa.req_data[0 +: 32] = 32'h1111_0000;
    ifa.req = 4'b0001;
    n = 0;
    while (ifa.tx_start !== 1'b1 && n < 50) begin step(); n++; end
    checks++; if (n !== 11) begin errors++; $display("FAIL single_gap: next start after %0d cycles want 11", n); end
    ifa.req = '0;
    repeat (3) step();
    ifa.tx_done = 1'b1; step(); ifa.tx_done = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_round_robin();
    int          exp_seq [8];
    logic [31:0] words [4];
    int          n;
    int          e;
    exp_seq = '{0, 1, 2, 3, 0, 1, 3, 1};
    rst = 1'b1; step(); rst = 1'b0; step();
    for (int r = 0; r < 4; r++) begin
      words[r] = 32'hC000_0000 | 32'(r);
      ifa.req_data[r*32 +: 32] = words[r];
    end
    ifa.req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) ifa.req = 4'b1010;
      e = exp_seq[i];
      n = 0;
      while (ifa.gnt === 4'b0 && n < 40) begin step(); n++; end
      checks++; if (ifa.gnt !== (4'b0001 << e) || ifa.cur_id !== 2'(e)) begin errors++; $display("FAIL rr_grant_%0d: gnt %b id %0d want id %0d", i, ifa.gnt, ifa.cur_id, e); end
      checks++; if (ifa.tx_din !== words[e]) begin errors++; $display("FAIL rr_din_%0d: got %h want %h", i, ifa.tx_din, words[e]); end
      words[e] = words[e] + 32'h100;
      ifa.req_data[e*32 +: 32] = words[e];
      if (i == 7) ifa.req = '0;
      repeat (3) step();
      ifa.tx_done = 1'b1; step(); ifa.tx_done = 1'b0;
    end
    repeat (15) step();
  endtask

  task automatic test_timeout();
    int n;
    int seen_done;
    ift.req_data = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    ift.req = 4'b0010;
    step();
    checks++; if (ift.gnt !== 4'b0010 || ift.tx_start !== 1'b1) begin errors++; $display("FAIL to_grant: gnt %b start %b want 0010 1", ift.gnt, ift.tx_start); end
    ift.req = '0;
    n = 0; seen_done = 0;
    while (ift.tx_abort !== 1'b1 && n < 200) begin
      step(); n++;
      if (ift.frm_done !== 4'b0) seen_done++;
    end
    checks++; if (n !== 101) begin errors++; $display("FAIL to_latency: abort after %0d cycles want 101", n); end
    checks++; if (ift.frm_err !== 4'b0010 || seen_done !== 0) begin errors++; $display("FAIL to_err: err %b done_seen %0d want 0010 0", ift.frm_err, seen_done); end
    ift.req = 4'b0110;
    n = 0;
    while (ift.gnt === 4'b0 && n < 40) begin step(); n++; end
    checks++; if (ift.gnt !== 4'b0100) begin errors++; $display("FAIL to_ptr: gnt %b want 0100", ift.gnt); end
    ift.req = '0;
    n = 0;
    while (ift.tx_abort !== 1'b1 && n < 200) begin step(); n++; end
    repeat (12) step();
  endtask

  task automatic test_collision();
    int n;
    int bad;
    ift.req = 4'b1000;
    n = 0;
    while (ift.gnt === 4'b0 && n < 40) begin step(); n++; end
    checks++; if (ift.gnt !== 4'b1000) begin errors++; $display("FAIL coll_grant: gnt %b want 1000", ift.gnt); end
    ift.req = '0;
    bad = 0;
    repeat (100) begin
      step();
      if (ift.frm_err !== 4'b0 || ift.tx_abort !== 1'b0 || ift.frm_done !== 4'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL coll_early: %0d early end pulses want 0", bad); end
    ift.tx_done = 1'b1; step(); ift.tx_done = 1'b0;
    checks++; if (ift.frm_done !== 4'b1000 || ift.frm_err !== 4'b0 || ift.tx_abort !== 1'b0) begin errors++; $display("FAIL coll_done: done %b err %b abort %b want 1000 0000 0", ift.frm_done, ift.frm_err, ift.tx_abort); end
    step();
    checks++; if (ift.frm_err !== 4'b0 || ift.tx_abort !== 1'b0) begin errors++; $display("FAIL coll_late: err %b abort %b want 0", ift.frm_err, ift.tx_abort); end
    repeat (12) step();
  endtask

  task automatic test_reset_mid_run();
    int n;
    int bad;
    ifa.req_data = {32'hE3E3_0003, 32'hE2E2_0002, 32'hE1E1_0001, 32'hE0E0_0000};
    ifa.req = 4'b0100;
    n = 0;
    while (ifa.gnt === 4'b0 && n < 40) begin step(); n++; end
    checks++; if (ifa.gnt !== 4'b0100) begin errors++; $display("FAIL rst_grant: gnt %b want 0100", ifa.gnt); end
    ifa.req = '0;
    repeat (50) step();
    checks++; if (ifa.busy !== 1'b1 || ifa.tx_din !== 32'hE2E2_0002) begin errors++; $display("FAIL rst_pre: busy %b din %h want 1 e2e20002", ifa.busy, ifa.tx_din); end
    rst = 1'b1;
    #1;
    checks++; if (ifa.busy !== 1'b0 || ifa.tx_din !== 32'h0 || ifa.cur_id !== 2'd0 || ifa.tx_start !== 1'b0) begin errors++; $display("FAIL rst_async: busy %b din %h id %0d start %b want all 0", ifa.busy, ifa.tx_din, ifa.cur_id, ifa.tx_start); end
    #2;
    rst = 1'b0;
    ifa.req = 4'b1001;
    n = 0; bad = 0;
    while (ifa.gnt === 4'b0 && n < 40) begin
      step(); n++;
      if (ifa.frm_done !== 4'b0 || ifa.frm_err !== 4'b0) bad++;
    end
    checks++; if (ifa.gnt !== 4'b0001 || bad !== 0) begin errors++; $display("FAIL rst_regrant: gnt %b end_pulses %0d want 0001 0", ifa.gnt, bad); end
    ifa.req = '0;
  endtask

  task automatic test_gap_withdraw();
    int seen;
    repeat (2) step();
    ifa.tx_done = 1'b1; step(); ifa.tx_done = 1'b0;
    checks++; if (ifa.frm_done !== 4'b0001) begin errors++; $display("FAIL gap_done: done %b want 0001", ifa.frm_done); end
    ifa.req = 4'b0010;
    seen = 0;
    repeat (10) begin step(); if (ifa.gnt !== 4'b0) seen++; end
    ifa.req = '0;
    repeat (5) begin step(); if (ifa.gnt !== 4'b0) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL gap_no_grant: %0d grants want 0", seen); end
    checks++; if (ifa.busy !== 1'b0 || ifa.tx_din !== 32'hE0E0_0000) begin errors++; $display("FAIL gap_idle: busy %b din %h want 0 e0e00000", ifa.busy, ifa.tx_din); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_timeout();
    test_collision();
    test_reset_mid_run();
    test_gap_withdraw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
